rv_stream_sink: RTL and testbench

//  Consumer end of the team's valid/ready stream: drives in_ready, accepts beats, checks them.

---
 rtl/rv_stream_sink_if.sv | 27 ++
 rtl/rv_stream_sink.sv | 171 +++++++++++++++++
 tb/tb_rv_stream_sink.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv_stream_sink_if.sv
// ----------------------------------------------------------------------------
// rv_stream_sink_if
// Valid/ready stream bundle carrying beats from a source into the stream sink.
//   in_valid  source -> sink   beat valid
//   in_data   source -> sink   beat payload, DATA_W bits
//   in_ready  sink   -> source sink can take a beat this cycle
// master: the source side (drives valid/data). slave: the sink side (drives ready).
// ----------------------------------------------------------------------------
interface rv_stream_sink_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/rv_stream_sink.sv
// ----------------------------------------------------------------------------
// rv_stream_sink
// Consumer end of a valid/ready stream. Generates programmable backpressure,
// checks accepted beats against an incrementing sequence and flags source-side
// protocol violations (valid dropped or data changed while stalled).
// Ports:
//   clk, rst          clock (rising edge) and asynchronous active-high reset
//   start             pulse: load expected <= seed, clear counters/flags, enter RUN
//   stop              pulse: return to IDLE, counters/flags retained
//   seed              first expected data value, sampled on start
//   stall_mode        00 always ready, 01 alternate, 10 LFSR, 11 never ready
//   in_if             stream slave port (in_valid, in_data in; in_ready out)
//   beat_cnt/err_cnt  saturating accepted-beat and data-mismatch counters
//   data_err          sticky data mismatch flag
//   proto_err         sticky source protocol violation flag
//   busy              high while in RUN
//   last_data         data of the most recently accepted beat
// ----------------------------------------------------------------------------
module rv_stream_sink #(
    parameter int          DATA_W    = 32,
    parameter int          CNT_W     = 16,
    parameter int          INCR      = 1,
    parameter logic [15:0] LFSR_INIT = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic [DATA_W-1:0]  seed,
    input  logic [1:0]         stall_mode,
    rv_stream_sink_if.slave    in_if,
    output logic [CNT_W-1:0]   beat_cnt,
    output logic [CNT_W-1:0]   err_cnt,
    output logic               data_err,
    output logic               proto_err,
    output logic               busy,
    output logic [DATA_W-1:0]  last_data
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q, state_d;
    logic               ready_q, ready_d;
    logic               tgl_q, tgl_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic [DATA_W-1:0]  expected_q, expected_d;
    logic [CNT_W-1:0]   beat_q, beat_d;
    logic [CNT_W-1:0]   err_q, err_d;
    logic               derr_q, derr_d;
    logic               perr_q, perr_d;
    logic [DATA_W-1:0]  last_q, last_d;
    logic               vq_q, vq_d;
    logic [DATA_W-1:0]  dq_q, dq_d;
    logic               accept;

    assign accept = in_if.in_valid & ready_q;

    // Control path: next state, pattern generators and the registered ready.
    // in_ready is computed from the *next* state so the first RUN cycle after
    // start already presents the mode's ready value, and it never depends
    // combinationally on in_valid.
    always_comb begin
        state_d = state_q;
        tgl_d   = tgl_q;
        lfsr_d  = lfsr_q;
        ready_d = 1'b0;

        if (start) begin
            state_d = RUN;
        end else if (stop) begin
            state_d = IDLE;
        end

        if (state_d == RUN) begin
            // Alternate pattern restarts at 1 on every start.
            tgl_d  = start ? 1'b1 : ~tgl_q;
            // Fibonacci LFSR, shift right, taps 16,14,13,11.
            lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
            case (stall_mode)
                2'b00:   ready_d = 1'b1;
                2'b01:   ready_d = tgl_d;
                2'b10:   ready_d = lfsr_d[0];
                default: ready_d = 1'b0;
            endcase
        end
    end

    // Data path: sequence checking, saturating counters and protocol watch.
    // The expected value resyncs to the received data on every accept so a
    // single corrupted beat produces exactly one error.
    always_comb begin
        expected_d = expected_q;
        beat_d     = beat_q;
        err_d      = err_q;
        derr_d     = derr_q;
        perr_d     = perr_q;
        last_d     = last_q;
        vq_d       = start ? 1'b0 : (in_if.in_valid & ~ready_q);
        dq_d       = in_if.in_data;

        if (accept) begin
            last_d = in_if.in_data;
        end

        if (start) begin
            expected_d = seed;
            beat_d     = '0;
            err_d      = '0;
            derr_d     = 1'b0;
            perr_d     = 1'b0;
        end else begin
            if (accept) begin
                if (in_if.in_data != expected_q) begin
                    derr_d = 1'b1;
                    if (err_q != '1) begin
                        err_d = err_q + CNT_W'(1);
                    end
                end
                expected_d = in_if.in_data + DATA_W'(INCR);
                if (beat_q != '1) begin
                    beat_d = beat_q + CNT_W'(1);
                end
            end
            // A beat stalled last cycle must still be offered, unchanged.
            if ((state_q == RUN) && vq_q &&
                (!in_if.in_valid || (in_if.in_data != dq_q))) begin
                perr_d = 1'b1;
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ready_q    <= 1'b0;
            tgl_q      <= 1'b0;
            lfsr_q     <= LFSR_INIT;
            expected_q <= '0;
            beat_q     <= '0;
            err_q      <= '0;
            derr_q     <= 1'b0;
            perr_q     <= 1'b0;
            last_q     <= '0;
            vq_q       <= 1'b0;
            dq_q       <= '0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            tgl_q      <= tgl_d;
            lfsr_q     <= lfsr_d;
            expected_q <= expected_d;
            beat_q     <= beat_d;
            err_q      <= err_d;
            derr_q     <= derr_d;
            perr_q     <= perr_d;
            last_q     <= last_d;
            vq_q       <= vq_d;
            dq_q       <= dq_d;
        end
    end

    assign in_if.in_ready = ready_q;
    assign beat_cnt       = beat_q;
    assign err_cnt        = err_q;
    assign data_err       = derr_q;
    assign proto_err      = perr_q;
    assign busy           = (state_q == RUN);
    assign last_data      = last_q;

endmodule

// File: tb/tb_rv_stream_sink.sv
// ----------------------------------------------------------------------------
// tb_rv_stream_sink
// Scoreboard bench for rv_stream_sink. The driver pushes the expected counter
// and flag state for every beat it offers; a monitor pops one entry per
// observed handshake and compares.
// ----------------------------------------------------------------------------
module tb_rv_stream_sink;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;
    localparam int INCR   = 1;
    localparam int SAT    = 65535;

    typedef struct {
        logic [31:0] data;
        int          beats;
        int          errs;
        bit          derr;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              stop;
    logic [31:0]       seed;
    logic [1:0]        stall_mode;
    logic [CNT_W-1:0]  beat_cnt;
    logic [CNT_W-1:0]  err_cnt;
    logic              data_err;
    logic              proto_err;
    logic              busy;
    logic [31:0]       last_data;

    rv_stream_sink_if #(.DATA_W(DATA_W)) bus ();

    rv_stream_sink #(
        .DATA_W(DATA_W), .CNT_W(CNT_W), .INCR(INCR), .LFSR_INIT(16'hACE1)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .seed(seed),
        .stall_mode(stall_mode), .in_if(bus), .beat_cnt(beat_cnt),
        .err_cnt(err_cnt), .data_err(data_err), .proto_err(proto_err),
        .busy(busy), .last_data(last_data)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    exp_t        sbq[$];
    bit          readyLog[$];
    int          cycleCount = 0;

    // Reference model: what the sink should have seen since the last start.
    logic [31:0] mExpected;
    int          mBeats;
    int          mErrs;
    bit          mDataErr;

    // Generic comparison used by both the monitor and the directed checks.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cycleCount++;
    endtask

    task automatic modelStart(input logic [31:0] s);
        mExpected = s;
        mBeats    = 0;
        mErrs     = 0;
        mDataErr  = 0;
    endtask

    task automatic doStart(input logic [31:0] s, input logic [1:0] mode);
        seed       = s;
        stall_mode = mode;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        modelStart(s);
    endtask

    // Offer one beat, record the expected post-accept state, wait for the handshake.
    task automatic applyStimulus(input logic [31:0] d);
        exp_t e;
        bit   rdy;
        bit   done;
        if (d !== mExpected) begin
            if (mErrs < SAT) mErrs++;
            mDataErr = 1;
        end
        mExpected = d + 32'(INCR);
        if (mBeats < SAT) mBeats++;
        e.data  = d;
        e.beats = mBeats;
        e.errs  = mErrs;
        e.derr  = mDataErr;
        sbq.push_back(e);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        done = 0;
        for (int i = 0; i < 50 && !done; i++) begin
            rdy = bus.in_ready;
            readyLog.push_back(rdy);
            tick();
            if (rdy) done = 1;
        end
        bus.in_valid = 1'b0;
        checkOutput("accept_within_bound", 32'(done), 32'd1);
    endtask

    function automatic int countOnes();
        int n = 0;
        foreach (readyLog[i]) n += int'(readyLog[i]);
        return n;
    endfunction

    // Monitor: one scoreboard entry per handshake seen at an edge.
    initial begin : monitor
        bit   acc;
        exp_t e;
        forever begin
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready && !rst;
            @(posedge clk);
            #1;
            if (acc && !rst) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_accept: got beat %h, expected none", last_data);
                end else begin
                    e = sbq.pop_front();
                    checkOutput("sb_last_data", last_data, e.data);
                    checkOutput("sb_beat_cnt", 32'(beat_cnt), 32'(e.beats));
                    checkOutput("sb_err_cnt", 32'(err_cnt), 32'(e.errs));
                    checkOutput("sb_data_err", 32'(data_err), 32'(e.derr));
                end
            end
        end
    end

    initial begin : stimulus
        logic [31:0] d;
        int          zeros;
        rst          = 1'b1;
        start        = 1'b0;
        stop         = 1'b0;
        seed         = '0;
        stall_mode   = 2'b00;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        modelStart('0);

        // Reset state.
        #2;
        checkOutput("rst_in_ready", 32'(bus.in_ready), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_beat_cnt", 32'(beat_cnt), 0);
        checkOutput("rst_err_cnt", 32'(err_cnt), 0);
        checkOutput("rst_flags", {30'd0, data_err, proto_err}, 0);
        checkOutput("rst_last_data", last_data, 0);
        tick();
        rst = 1'b0;
        tick();

        // T1: back-to-back beats with no backpressure.
        $display("[TB] T1 always-ready stream");
        doStart(32'h1111_1111, 2'b00);
        checkOutput("t1_busy", 32'(busy), 1);
        checkOutput("t1_ready_first", 32'(bus.in_ready), 1);
        readyLog.delete();
        for (int i = 0; i < 4; i++) applyStimulus(32'h1111_1111 + 32'(i));
        checkOutput("t1_ready_ones", 32'(countOnes()), 4);
        checkOutput("t1_ready_cycles", 32'(readyLog.size()), 4);
        checkOutput("t1_beat_cnt", 32'(beat_cnt), 4);
        checkOutput("t1_last_data", last_data, 32'h1111_1114);

        // T2: never-ready holds a beat, then release.
        $display("[TB] T2 full stall then release");
        stall_mode = 2'b11;
        tick();
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hDEAD_BEEF;
        zeros = 0;
        for (int i = 0; i < 5; i++) begin
            zeros += int'(!bus.in_ready);
            tick();
        end
        checkOutput("t2_ready_low", 32'(zeros), 5);
        checkOutput("t2_beat_hold", 32'(beat_cnt), 4);
        checkOutput("t2_proto_ok", 32'(proto_err), 0);
        stall_mode = 2'b00;
        tick();
        checkOutput("t2_ready_back", 32'(bus.in_ready), 1);
        applyStimulus(32'hDEAD_BEEF);

        // T3: one bad beat, then resync without error cascade.
        $display("[TB] T3 data mismatch and resync");
        doStart(32'h2222_2222, 2'b00);
        applyStimulus(32'h2222_2223);
        applyStimulus(32'h2222_2224);
        checkOutput("t3_err_cnt", 32'(err_cnt), 1);

        // Stop keeps the counters and drops ready.
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checkOutput("stop_busy", 32'(busy), 0);
        checkOutput("stop_ready", 32'(bus.in_ready), 0);
        checkOutput("stop_beats_kept", 32'(beat_cnt), 2);

        // T4: protocol violations while stalled.
        $display("[TB] T4 protocol violations");
        doStart(32'h0, 2'b11);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hAAAA_AAAA;
        tick();
        tick();
        checkOutput("t4_proto_hold_ok", 32'(proto_err), 0);
        bus.in_data = 32'hBBBB_BBBB;
        tick();
        checkOutput("t4_proto_data", 32'(proto_err), 1);
        bus.in_valid = 1'b0;
        doStart(32'h0, 2'b11);
        checkOutput("t4_proto_cleared", 32'(proto_err), 0);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hCCCC_CCCC;
        tick();
        tick();
        bus.in_valid = 1'b0;
        tick();
        checkOutput("t4_proto_drop", 32'(proto_err), 1);
        checkOutput("t4_no_beats", 32'(beat_cnt), 0);

        // T5: alternate and LFSR backpressure.
        $display("[TB] T5 alternate and LFSR backpressure");
        doStart(32'h5000_0000, 2'b01);
        readyLog.delete();
        for (int i = 0; i < 3; i++) applyStimulus(32'h5000_0000 + 32'(i));
        readyLog.push_back(bus.in_ready);
        checkOutput("t5_ready_pattern",
                    {26'd0, readyLog[0], readyLog[1], readyLog[2], readyLog[3], readyLog[4], readyLog[5]},
                    32'b101010);
        checkOutput("t5_alt_beats", 32'(beat_cnt), 3);
        d = $urandom;
        doStart(d, 2'b10);
        cycleCount = 0;
        while (cycleCount < 1000) applyStimulus(mExpected);
        tick();
        checkOutput("t5_lfsr_beats_in_range", 32'((beat_cnt >= 400) && (beat_cnt <= 600)), 1);
        checkOutput("t5_lfsr_err_cnt", 32'(err_cnt), 0);

        // Random mode changes, gaps and occasional corrupted beats.
        $display("[TB] random traffic");
        doStart($urandom, 2'b00);
        for (int i = 0; i < 40; i++) begin
            stall_mode = 2'($urandom_range(0, 2));
            d = ($urandom_range(0, 3) == 0) ? $urandom : mExpected;
            applyStimulus(d);
            if ($urandom_range(0, 1) == 1) tick();
        end
        tick();
        checkOutput("rnd_err_cnt", 32'(err_cnt), 32'(mErrs));
        checkOutput("rnd_beat_cnt", 32'(beat_cnt), 32'(mBeats));

        // T6: asynchronous reset mid-stream, then counter wrap of expected.
        $display("[TB] T6 async reset and wrap");
        doStart(32'h3333_0000, 2'b00);
        applyStimulus(32'h3333_0000);
        applyStimulus(32'h3333_0001);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("t6_ready", 32'(bus.in_ready), 0);
        checkOutput("t6_busy", 32'(busy), 0);
        checkOutput("t6_beat_cnt", 32'(beat_cnt), 0);
        checkOutput("t6_err_cnt", 32'(err_cnt), 0);
        checkOutput("t6_flags", {30'd0, data_err, proto_err}, 0);
        checkOutput("t6_last_data", last_data, 0);
        tick();
        rst = 1'b0;
        zeros = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            zeros += int'(!bus.in_ready);
        end
        checkOutput("t6_ready_idle", 32'(zeros), 3);
        doStart(32'hFFFF_FFFF, 2'b00);
        applyStimulus(32'hFFFF_FFFF);
        applyStimulus(32'h0000_0000);
        tick();
        checkOutput("t6_wrap_err_cnt", 32'(err_cnt), 0);
        checkOutput("t6_wrap_beats", 32'(beat_cnt), 2);

        tick();
        checkOutput("sb_drained", 32'(sbq.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
